neuron_mac_core: RTL

- Parametrised successor of the single-neuron datapath: one neuron computing act(sum_i(x_i*w_i) + b) over N_INPUTS signed fixed-point inputs.
- Inputs arrive as a valid/ready stream; weights are fetched from an external synchronous BRAM; result leaves through a valid/ready port.
- Sits inside an MLP layer; the layer controller instantiates one neuron_mac_core per output neuron.

---
 rtl/neuron_pkg.sv | 20 ++
 rtl/neuron_mac_core_if.sv | 35 +++
 rtl/neuron_requant.sv | 43 ++++
 rtl/neuron_mac_core.sv | 125 ++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared types, constants and width helpers for the neuron MAC core
package neuron_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ACCUM,
        DRAIN,
        OUT
    } state_t;

    localparam int ACT_NONE = 0;
    localparam int ACT_RELU = 1;

    // Wide enough that N_INPUTS full-scale products can never overflow the sum.
    function automatic int acc_width(input int data_w, input int n_inputs);
        return 2 * data_w + $clog2(n_inputs) + 1;
    endfunction

endpackage

// File: rtl/neuron_mac_core_if.sv
// rtl/neuron_mac_core_if.sv - control, sample stream, weight BRAM and result ports of one neuron
interface neuron_mac_core_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              pi_start;
    logic              pi_abort;
    logic [DATA_W-1:0] pi_bias;
    logic [ADDR_W-1:0] pi_weight_base;
    logic              pi_in_valid;
    logic [DATA_W-1:0] pi_in_data;
    logic              po_in_ready;
    logic              po_weight_en;
    logic [ADDR_W-1:0] po_weight_addr;
    logic [DATA_W-1:0] pi_weight_data;
    logic              po_out_valid;
    logic [DATA_W-1:0] po_out_data;
    logic              pi_out_ready;
    logic              po_sat;
    logic              po_busy;

    modport slave (
        input  pi_start, pi_abort, pi_bias, pi_weight_base,
        input  pi_in_valid, pi_in_data, pi_weight_data, pi_out_ready,
        output po_in_ready, po_weight_en, po_weight_addr,
        output po_out_valid, po_out_data, po_sat, po_busy
    );

    modport master (
        output pi_start, pi_abort, pi_bias, pi_weight_base,
        output pi_in_valid, pi_in_data, pi_weight_data, pi_out_ready,
        input  po_in_ready, po_weight_en, po_weight_addr,
        input  po_out_valid, po_out_data, po_sat, po_busy
    );
endinterface

// File: rtl/neuron_requant.sv
// rtl/neuron_requant.sv - bias align, round half up, saturate and activate the accumulated sum
module neuron_requant
    import neuron_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int FRAC_W   = 7,
    parameter int ACC_W    = 43,
    parameter int ACT_MODE = ACT_RELU
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic        [DATA_W-1:0] bias,
    output logic        [DATA_W-1:0] data,
    output logic                     sat
);
    localparam int S_W = ACC_W + 2;
    localparam logic signed [S_W-1:0] HALF  = S_W'(1) <<< (FRAC_W - 1);
    localparam logic signed [S_W-1:0] R_MAX = {{(S_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [S_W-1:0] R_MIN = {{(S_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [S_W-1:0] bias_ext;
    logic signed [S_W-1:0] s;
    logic signed [S_W-1:0] r;

    always_comb begin
        bias_ext = {{(S_W-DATA_W){bias[DATA_W-1]}}, bias};
        s        = {{2{acc[ACC_W-1]}}, acc} + (bias_ext <<< FRAC_W) + HALF;
        r        = s >>> FRAC_W;
        data     = r[DATA_W-1:0];
        sat      = 1'b0;
        if (r > R_MAX) begin
            data = {1'b0, {(DATA_W-1){1'b1}}};
            sat  = 1'b1;
        end else if (r < R_MIN) begin
            data = {1'b1, {(DATA_W-1){1'b0}}};
            sat  = 1'b1;
        end
        // ReLU clamps negatives to zero, which is not reported as saturation.
        if (ACT_MODE == ACT_RELU && r < 0) begin
            data = '0;
            sat  = 1'b0;
        end
    end
endmodule

// File: rtl/neuron_mac_core.sv
// rtl/neuron_mac_core.sv - one neuron: streamed x_i times BRAM w_i, summed, biased and activated
module neuron_mac_core
    import neuron_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int FRAC_W   = 7,
    parameter int N_INPUTS = 784,
    parameter int ADDR_W   = 16,
    parameter int ACT_MODE = ACT_RELU
) (
    input  logic               pi_clk,
    input  logic               pi_rst,
    neuron_mac_core_if.slave   bus
);
    localparam int ACC_W  = acc_width(DATA_W, N_INPUTS);
    localparam int PROD_W = 2 * DATA_W;
    localparam int CNT_W  = $clog2(N_INPUTS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_INPUTS - 1);

    state_t                    state, state_nx;
    logic [CNT_W-1:0]          cnt;
    logic [ADDR_W-1:0]         addr;
    logic [DATA_W-1:0]         bias_q;
    logic signed [PROD_W-1:0]  prod;
    logic                      prod_v;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   prod_ext;
    logic                      drain_cnt;
    logic [DATA_W-1:0]         out_data;
    logic                      out_sat;
    logic                      accept;
    logic                      last_accept;
    logic                      fetch_en;
    logic                      start_ok;
    logic [DATA_W-1:0]         rq_data;
    logic                      rq_sat;

    always_comb begin
        state_nx    = state;
        accept      = 1'b0;
        last_accept = 1'b0;
        fetch_en    = 1'b0;
        case (state)
            IDLE:  if (bus.pi_start) state_nx = FETCH;
            FETCH: begin
                fetch_en = 1'b1;
                state_nx = ACCUM;
            end
            ACCUM: begin
                accept      = bus.pi_in_valid;
                last_accept = accept && (cnt == LAST_IDX);
                // The final sample's weight is already on the bus; no prefetch past the vector.
                fetch_en    = accept && !last_accept;
                if (last_accept) state_nx = DRAIN;
            end
            DRAIN: if (drain_cnt) state_nx = OUT;
            OUT:   if (bus.pi_out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (bus.pi_abort) state_nx = IDLE;
    end

    assign start_ok = (state == IDLE) && bus.pi_start && !bus.pi_abort;
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

    always_ff @(posedge pi_clk or posedge pi_rst) begin
        if (pi_rst) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge pi_clk or posedge pi_rst) begin
        if (pi_rst) begin
            cnt       <= '0;
            addr      <= '0;
            bias_q    <= '0;
            prod      <= '0;
            prod_v    <= 1'b0;
            acc       <= '0;
            drain_cnt <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            prod_v <= accept && !bus.pi_abort;
            if (accept)
                prod <= PROD_W'($signed(bus.pi_in_data)) * PROD_W'($signed(bus.pi_weight_data));
            if (start_ok) begin
                bias_q    <= bus.pi_bias;
                addr      <= bus.pi_weight_base;
                cnt       <= '0;
                acc       <= '0;
                drain_cnt <= 1'b0;
            end else begin
                if (prod_v)   acc  <= acc + prod_ext;
                if (fetch_en) addr <= addr + ADDR_W'(1);
                if (accept && !last_accept) cnt <= cnt + CNT_W'(1);
                if (state == DRAIN) drain_cnt <= ~drain_cnt;
                // Second DRAIN cycle: the last product has landed in acc.
                if (state == DRAIN && drain_cnt) begin
                    out_data <= rq_data;
                    out_sat  <= rq_sat;
                end
            end
        end
    end

    neuron_requant #(
        .DATA_W   (DATA_W),
        .FRAC_W   (FRAC_W),
        .ACC_W    (ACC_W),
        .ACT_MODE (ACT_MODE)
    ) u_requant (
        .acc  (acc),
        .bias (bias_q),
        .data (rq_data),
        .sat  (rq_sat)
    );

    assign bus.po_in_ready    = (state == ACCUM);
    assign bus.po_weight_en   = fetch_en;
    assign bus.po_weight_addr = addr;
    assign bus.po_out_valid   = (state == OUT);
    assign bus.po_out_data    = out_data;
    assign bus.po_sat         = out_sat;
    assign bus.po_busy        = (state != IDLE);
endmodule
